decentering_block: RTL

- Inverse of the whitening-path centering stage: restores the per-channel mean onto separated samples leaving the FastICA core.
- Channel means are latched once at GO. The block then streams exactly NUM_SAMPLES 4-channel frames through a valid/ready pipeline, computing x_out = sat16(y_in + mean).
- Sits between the separation output and the result buffer.
- Raises done for one cycle after the last frame is consumed.

---
 rtl/decentering_block.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/decentering_block.sv
// -----------------------------------------------------------------------------
// decentering_block
//
// Purpose:
//   This block undoes the centering stage of the whitening path. It adds the
//   per-channel mean back onto the separated samples that leave the FastICA
//   core, before they go into the result buffer.
//   The channel means are captured once, on the GO cycle. After that the block
//   streams exactly NUM_SAMPLES four-channel frames through a valid/ready
//   pipeline with one output register, computing:
//       x_out = sat16(y_in + mean)
//   When the last frame has been taken downstream, done pulses for one cycle.
//
// Parameters:
//   NUM_SAMPLES  frames processed per run (1 .. 65535)
//   CNT_W        sample counter width, 2**CNT_W > NUM_SAMPLES
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset
//   GO                  start pulse, honoured only while idle
//   mean1_in..mean4_in  signed channel means, captured on the GO cycle
//   in_valid            a frame is present on y1_in..y4_in
//   in_ready            the block accepts a frame this cycle
//   y1_in..y4_in        signed separated samples
//   out_valid           x1_out..x4_out hold a valid frame
//   out_ready           downstream accepts the frame
//   x1_out..x4_out      signed de-centered samples (saturated to 16 bits)
//   busy                high from GO acceptance until done
//   done                one-cycle pulse at the end of a run
//   sat_flag            sticky: some channel clipped during the current run
// -----------------------------------------------------------------------------
module decentering_block #(
    parameter int NUM_SAMPLES = 1024,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               GO,
    input  logic signed [15:0] mean1_in,
    input  logic signed [15:0] mean2_in,
    input  logic signed [15:0] mean3_in,
    input  logic signed [15:0] mean4_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] y1_in,
    input  logic signed [15:0] y2_in,
    input  logic signed [15:0] y3_in,
    input  logic signed [15:0] y4_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] x1_out,
    output logic signed [15:0] x2_out,
    output logic signed [15:0] x3_out,
    output logic signed [15:0] x4_out,
    output logic               busy,
    output logic               done,
    output logic               sat_flag
);

    localparam int NCH = 4;

    // The counter value at which the final frame of the run is accepted.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             sat_flag_reg;

    // The channel ports are gathered into arrays so that the datapath can be
    // built once per channel.
    logic signed [15:0] mean_in_arr [NCH];
    logic signed [15:0] y_in_arr    [NCH];
    logic signed [15:0] x_out_arr   [NCH];
    logic [NCH-1:0]     clip_vec;

    logic go_accept;
    logic in_xfer;
    logic out_xfer;

    assign mean_in_arr[0] = mean1_in;
    assign mean_in_arr[1] = mean2_in;
    assign mean_in_arr[2] = mean3_in;
    assign mean_in_arr[3] = mean4_in;

    assign y_in_arr[0] = y1_in;
    assign y_in_arr[1] = y2_in;
    assign y_in_arr[2] = y3_in;
    assign y_in_arr[3] = y4_in;

    // Handshake decode.
    // in_ready has to stay combinational on out_ready. That is how a single
    // output register can take one frame every cycle: the frame already in
    // the register leaves on the same edge that the next frame loads.
    assign go_accept = (state_reg == ST_IDLE) && GO;
    assign in_ready  = (state_reg == ST_RUN) && (!out_valid_reg || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid_reg && out_ready;

    // -------------------------------------------------------------------------
    // Per-channel datapath: mean register, 17-bit add, clamp, output register
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic signed [15:0] mean_reg;
            logic signed [15:0] x_reg;
            logic        [16:0] sum;
            logic               clip;
            logic signed [15:0] sat_val;

            // Sign-extend both operands to 17 bits, so the sum cannot wrap.
            assign sum = {y_in_arr[gi][15], y_in_arr[gi]} + {mean_reg[15], mean_reg};

            // The result fits in 16 bits only when the top two bits agree.
            // If they differ, bit 16 gives the true sign, and that decides
            // which rail to clamp to.
            assign clip    = sum[16] ^ sum[15];
            assign sat_val = !clip   ? sum[15:0]   :
                             sum[16] ? 16'sh8000   :
                                       16'sh7FFF;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mean_reg <= '0;
                    x_reg    <= '0;
                end else begin
                    if (go_accept) begin
                        mean_reg <= mean_in_arr[gi];
                    end
                    // x_reg loads only on an input transfer. That keeps it
                    // frozen while the output is stalled.
                    if (in_xfer) begin
                        x_reg <= sat_val;
                    end
                end
            end

            assign clip_vec[gi]  = clip;
            assign x_out_arr[gi] = x_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM with registered status outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            sat_flag_reg  <= 1'b0;
        end else begin
            // done is a single-cycle strobe. Only the DRAIN exit sets it.
            done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (GO) begin
                        cnt_reg      <= '0;
                        sat_flag_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (in_xfer) begin
                        // A new frame replaces whatever is in the output
                        // register. Any output handshake on this same edge
                        // is absorbed, and out_valid stays high.
                        out_valid_reg <= 1'b1;
                        cnt_reg       <= cnt_reg + CNT_W'(1);
                        if (|clip_vec) begin
                            sat_flag_reg <= 1'b1;
                        end
                        if (cnt_reg == LAST_IDX) begin
                            state_reg <= ST_DRAIN;
                        end
                    end else if (out_xfer) begin
                        out_valid_reg <= 1'b0;
                    end
                end

                ST_DRAIN: begin
                    // DRAIN is entered only on an input transfer, so the
                    // output register is always full here.
                    if (out_xfer) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= ST_FIN;
                    end
                end

                ST_FIN: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign sat_flag  = sat_flag_reg;

    assign x1_out = x_out_arr[0];
    assign x2_out = x_out_arr[1];
    assign x3_out = x_out_arr[2];
    assign x4_out = x_out_arr[3];

endmodule
